// File: rtl/la_pkg.sv
// Shared definitions for the logic-analyser capture path.
// DEPTH : number of sample RAM entries (power of two)
// AW    : RAM address width, log2(DEPTH)
// state_e : capture controller states
package la_pkg;

  localparam int DEPTH = 512;
  localparam int AW    = $clog2(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_ARMED = 3'd2,
    S_POST  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/cap_addr_cnt.sv
// Wrapping RAM write-address counter for the capture path.
// clk  : rising-edge clock
// clr  : synchronous clear to address 0 (takes priority over en)
// en   : advance by one; wraps DEPTH-1 -> 0 because DEPTH is a power of two
// addr : current write address
module cap_addr_cnt
  import la_pkg::*;
(
  input  logic          clk,
  input  logic          clr,
  input  logic          en,
  output logic [AW-1:0] addr
);

  always_ff @(posedge clk) begin
    if (clr) begin
      addr <= '0;
    end else if (en) begin
      addr <= addr + AW'(1);
    end
  end

endmodule

// File: rtl/trig_capture.sv
// Pre/post-trigger capture controller for a circular sample RAM.
// Fills the RAM until DEPTH-trig_pos pre-trigger samples exist, waits for a
// qualified trigger, stores trig_pos post-trigger samples, then holds until
// run drops.
// clk, rst          : clock and synchronous active-high reset
// run               : level; 1 starts/keeps a capture, 0 aborts to IDLE
// smpl_en           : one-cycle strobe per decimated sample
// protTrig, chTrig  : trigger sources, selected by trig_src[0] / trig_src[1]
// trig_src, trig_pos: trigger select and post-trigger count, latched at start
// we, waddr         : RAM write strobe (same cycle as smpl_en) and address
// armed, triggered, capture_done : capture progress flags
// trace_end         : address of the last stored sample of a finished capture
// dbg_state         : current controller state
// Handshake: smpl_en is a valid-only strobe with no backpressure; every
// smpl_en seen while capturing produces exactly one we in the same cycle.
module trig_capture
  import la_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic          smpl_en,
  input  logic          protTrig,
  input  logic          chTrig,
  input  logic [1:0]    trig_src,
  input  logic [AW-1:0] trig_pos,
  output logic          we,
  output logic [AW-1:0] waddr,
  output logic          armed,
  output logic          triggered,
  output logic          capture_done,
  output logic [AW-1:0] trace_end,
  output state_e        dbg_state
);

  state_e        state_q, state_d;
  logic [AW:0]   smpl_cnt_q, smpl_cnt_d;
  logic [AW:0]   post_cnt_q, post_cnt_d;
  logic [1:0]    src_q, src_d;
  logic [AW-1:0] pos_q, pos_d;
  logic [AW-1:0] trace_end_q, trace_end_d;

  logic          active;
  logic          trig;
  logic [AW:0]   smpl_inc;
  logic [AW:0]   post_inc;
  logic [AW:0]   arm_pt;

  assign active   = (state_q == S_FILL) || (state_q == S_ARMED) || (state_q == S_POST);
  // Gating with run and rst makes an abort take effect with no further writes.
  assign we       = active && smpl_en && run && !rst;
  assign trig     = (src_q[0] && protTrig) || (src_q[1] && chTrig);
  assign smpl_inc = smpl_cnt_q + (AW+1)'(1);
  assign post_inc = post_cnt_q + (AW+1)'(1);
  // pos_q is never 0 (clamped when latched), so arm_pt stays in 1..DEPTH-1.
  assign arm_pt   = (AW+1)'(DEPTH) - {1'b0, pos_q};

  cap_addr_cnt u_addr (
    .clk  (clk),
    .clr  (rst),
    .en   (we),
    .addr (waddr)
  );

  always_comb begin
    state_d     = state_q;
    smpl_cnt_d  = smpl_cnt_q;
    post_cnt_d  = post_cnt_q;
    src_d       = src_q;
    pos_d       = pos_q;
    trace_end_d = trace_end_q;
    if (!run) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d    = S_FILL;
          smpl_cnt_d = '0;
          src_d      = trig_src;
          pos_d      = (trig_pos == '0) ? AW'(1) : trig_pos;
        end
        S_FILL: begin
          if (we) begin
            smpl_cnt_d = smpl_inc;
            if (smpl_inc == arm_pt) state_d = S_ARMED;
          end
        end
        S_ARMED: begin
          // A write in this cycle still belongs to the pre-trigger window.
          if (trig) begin
            state_d    = S_POST;
            post_cnt_d = '0;
          end
        end
        S_POST: begin
          if (we) begin
            post_cnt_d = post_inc;
            if (post_inc == {1'b0, pos_q}) begin
              state_d     = S_DONE;
              trace_end_d = waddr;
            end
          end
        end
        S_DONE:  state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      smpl_cnt_q  <= '0;
      post_cnt_q  <= '0;
      src_q       <= '0;
      pos_q       <= AW'(1);
      trace_end_q <= '0;
    end else begin
      state_q     <= state_d;
      smpl_cnt_q  <= smpl_cnt_d;
      post_cnt_q  <= post_cnt_d;
      src_q       <= src_d;
      pos_q       <= pos_d;
      trace_end_q <= trace_end_d;
    end
  end

  assign armed        = (state_q == S_ARMED) || (state_q == S_POST) || (state_q == S_DONE);
  assign triggered    = (state_q == S_POST) || (state_q == S_DONE);
  assign capture_done = (state_q == S_DONE);
  assign trace_end    = trace_end_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_trig_capture.sv
module tb_trig_capture;
  import la_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          run = 1'b0;
  logic          smpl_en = 1'b0;
  logic          protTrig = 1'b0;
  logic          chTrig = 1'b0;
  logic [1:0]    trig_src = 2'b00;
  logic [AW-1:0] trig_pos = '0;
  logic          we;
  logic [AW-1:0] waddr;
  logic          armed;
  logic          triggered;
  logic          capture_done;
  logic [AW-1:0] trace_end;
  state_e        dbg_state;

  trig_capture dut (
    .clk          (clk),
    .rst          (rst),
    .run          (run),
    .smpl_en      (smpl_en),
    .protTrig     (protTrig),
    .chTrig       (chTrig),
    .trig_src     (trig_src),
    .trig_pos     (trig_pos),
    .we           (we),
    .waddr        (waddr),
    .armed        (armed),
    .triggered    (triggered),
    .capture_done (capture_done),
    .trace_end    (trace_end),
    .dbg_state    (dbg_state)
  );

  int n_total = 0;
  int n_bad   = 0;
  bit chk_en  = 1'b0;
  int we_cnt  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A capture is described by how many samples were stored before and after
  // the trigger; all flags follow from those counts.
  bit  m_running = 0;  // a capture has started (run seen high out of idle)
  bit  m_trig    = 0;  // trigger accepted in this capture
  int  m_pre     = 0;  // samples stored before the trigger (incl. trigger cycle)
  int  m_post    = 0;  // samples stored after the trigger
  int  m_pos     = 1;
  int  m_src     = 0;
  int  m_addr    = 0;
  int  m_trace   = 0;
  logic [AW-1:0] exp_q[$];

  function automatic bit m_armed();
    return m_running && (m_pre >= DEPTH - m_pos);
  endfunction

  function automatic bit m_done();
    return m_running && m_trig && (m_post == m_pos);
  endfunction

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin
    bit exp_we;
    bit fire;
    logic [AW-1:0] a;
    exp_we = !rst && run && smpl_en && m_running && !m_done();
    if (chk_en) begin
      check("we", we, exp_we);
      check("waddr", waddr, m_addr);
      check("armed", armed, m_armed());
      check("triggered", triggered, m_trig);
      check("capture_done", capture_done, m_done());
      check("trace_end", trace_end, m_trace);
      if (exp_we) exp_q.push_back(AW'(m_addr));
      if (we === 1'b1) begin
        we_cnt++;
        if (exp_q.size() == 0) check("unexpected_write", 1, 0);
        else begin
          a = exp_q.pop_front();
          check("write_addr", waddr, a);
        end
      end
      exp_q.delete();
    end
    // advance the model to the state after the coming rising edge
    if (rst) begin
      m_running = 0; m_trig = 0; m_pre = 0; m_post = 0; m_addr = 0; m_trace = 0;
    end else if (!run) begin
      m_running = 0; m_trig = 0; m_pre = 0; m_post = 0;
    end else if (!m_running) begin
      m_running = 1; m_trig = 0; m_pre = 0; m_post = 0;
      m_src = int'(trig_src);
      m_pos = (trig_pos == 0) ? 1 : int'(trig_pos);
    end else begin
      fire = m_armed() && !m_trig &&
             ((m_src[0] && protTrig) || (m_src[1] && chTrig));
      if (exp_we) begin
        if (m_trig) begin
          m_post++;
          if (m_post == m_pos) m_trace = m_addr;
        end else begin
          m_pre++;
        end
        m_addr = (m_addr + 1) % DEPTH;
      end
      if (fire) m_trig = 1;
    end
  end

  // ---------------- driver ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int tp;
    int dens;
    int abort_at;
    int rst_at;
    int hold;

    step(2);
    rst = 1'b0;
    chk_en = 1'b1;
    check("rst_we", we, 0);
    check("rst_waddr", waddr, 0);
    check("rst_armed", armed, 0);
    check("rst_triggered", triggered, 0);
    check("rst_done", capture_done, 0);
    check("rst_trace_end", trace_end, 0);

    // Full capture from address 0: 384 fill writes, trigger 10 writes later,
    // 128 post writes -> last address (384+10+128-1) mod 512 = 9.
    we_cnt = 0;
    run = 1; smpl_en = 1; trig_src = 2'b01; trig_pos = AW'(128);
    step(1);
    step(100);
    protTrig = 1;              // ignored while filling
    step(1);
    protTrig = 0;
    trig_pos = AW'(20);        // ignored mid-capture
    step(282);
    check("d_armed_early", armed, 0);
    step(1);
    check("d_armed_384", armed, 1);
    check("d_trig_early", triggered, 0);
    step(9);
    protTrig = 1;
    step(1);
    protTrig = 0;
    check("d_triggered", triggered, 1);
    step(127);
    check("d_done_early", capture_done, 0);
    step(1);
    check("d_done", capture_done, 1);
    check("d_trace_end", trace_end, 9);
    check("d_we_count", we_cnt, 522);
    check("d_we_in_done", we, 0);
    step(3);
    check("d_waddr_frozen", waddr, 10);
    run = 0;
    step(1);
    check("d_done_clr", capture_done, 0);
    check("d_armed_clr", armed, 0);

    // Never-trigger source: stays armed however the triggers toggle.
    run = 1; trig_src = 2'b00; trig_pos = AW'(128);
    for (int k = 0; k < 700; k++) begin
      protTrig = k[0];
      chTrig = ~k[0];
      step(1);
    end
    check("n_armed", armed, 1);
    check("n_triggered", triggered, 0);
    check("n_done", capture_done, 0);
    protTrig = 0; chTrig = 0;
    rst = 1;
    step(1);
    rst = 0;
    check("r_armed", armed, 0);
    check("r_waddr", waddr, 0);
    check("r_we", we, 0);
    run = 0;
    step(2);

    // Randomised captures against the model.
    for (int c = 0; c < 12; c++) begin
      case ($urandom_range(0, 4))
        0: tp = 0;
        1: tp = 1;
        2: tp = DEPTH - 1;
        default: tp = $urandom_range(1, DEPTH - 1);
      endcase
      dens = $urandom_range(1, 4);
      trig_pos = AW'(tp);
      trig_src = 2'($urandom_range(0, 3));
      abort_at = ($urandom_range(0, 3) == 0) ? $urandom_range(5, 1500) : -1;
      rst_at   = ($urandom_range(0, 5) == 0) ? $urandom_range(5, 1500) : -1;
      run = 1;
      hold = 0;
      for (int k = 0; k < 4500; k++) begin
        smpl_en  = ($urandom_range(1, dens) == 1);
        protTrig = ($urandom_range(0, 15) == 0);
        chTrig   = ($urandom_range(0, 15) == 0);
        if ($urandom_range(0, 63) == 0) begin
          trig_pos = AW'($urandom_range(0, DEPTH - 1));
          trig_src = 2'($urandom_range(0, 3));
        end
        if (k == abort_at) run = 0;
        rst = (k == rst_at);
        step(1);
        rst = 0;
        if (m_done()) hold++;
        if (hold > 4) break;
      end
      run = 0;
      step(2);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
